line_buf_window: RTL and testbench

LINE_BUF_WINDOW -- requirements
Module: line_buf_window

---
 rtl/line_buf_window.sv | 195 +++++++++++++++++++
 tb/tb_line_buf_window.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buf_window.sv
// 3x3 sliding-window generator over a raster pixel stream.
// Two line buffers delay the incoming stream by one and two rows, and a 3x3
// register window holds the three most recent columns. Border taps are
// replaced by zero or by the clamped edge pixel when the window is emitted.
// After the last pixel of a frame, IMG_W+1 dummy samples are clocked through
// to drain the remaining windows.
module line_buf_window #(
  parameter int DW       = 8,
  parameter int IMG_W    = 256,
  parameter int IMG_H    = 256,
  parameter int PAD_MODE = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic            in_sof,
  input  logic [DW-1:0]   in_pixel,
  output logic            in_ready,
  output logic            out_valid,
  output logic [9*DW-1:0] out_win,
  output logic            out_eof
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;    // column of the next sample to enter
  logic [RW-1:0]   row_q, row_d;    // row of the next pixel to accept
  logic [CW-1:0]   ocol_q, ocol_d;  // centre column of the next window out
  logic [RW-1:0]   orow_q, orow_d;  // centre row of the next window out
  logic            ready_q;
  logic            out_valid_q, out_eof_q;
  logic [9*DW-1:0] out_win_q;

  logic [DW-1:0]   lb1_q [IMG_W];   // stream delayed by one row
  logic [DW-1:0]   lb2_q [IMG_W];   // stream delayed by two rows
  logic [9*DW-1:0] win_q, win_d;    // raw window, tap k at [k*DW +: DW]
  logic [9*DW-1:0] win_pad;

  logic            acc, adv, emit, last_in, last_out;
  logic [DW-1:0]   x, rd1, rd2;

  // Pick tap k of the raw window, redirecting taps that fall outside the
  // image towards the centre (clamp) or forcing them to zero.
  function automatic logic [DW-1:0] pick(input logic [9*DW-1:0] w, input int k,
                                         input logic top, input logic bot,
                                         input logic lft, input logic rgt);
    int   rs, cs;
    logic pad;
    rs  = k / 3;
    cs  = k % 3;
    pad = 1'b0;
    if (rs == 0 && top) begin rs = 1; pad = 1'b1; end
    if (rs == 2 && bot) begin rs = 1; pad = 1'b1; end
    if (cs == 0 && lft) begin cs = 1; pad = 1'b1; end
    if (cs == 2 && rgt) begin cs = 1; pad = 1'b1; end
    if (pad && PAD_MODE == 0) return '0;
    return w[(rs*3 + cs)*DW +: DW];
  endfunction

  assign acc      = in_valid & ready_q;
  assign x        = (state_q == FLUSH) ? '0 : in_pixel;
  assign rd1      = lb1_q[col_q];
  assign rd2      = lb2_q[col_q];
  assign last_in  = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign last_out = (orow_q == ROW_LAST) && (ocol_q == COL_LAST);

  assign in_ready  = ready_q;
  assign out_valid = out_valid_q;
  assign out_win   = out_win_q;
  assign out_eof   = out_eof_q;

  // Next state, stream advance and window-emit decisions
  always_comb begin
    state_d = state_q;
    adv     = 1'b0;
    emit    = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc && in_sof) begin
          adv     = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (acc) begin
          adv  = 1'b1;
          // first window is complete once pixel (1,1) arrives
          emit = (row_q != '0) && !((row_q == RW'(1)) && (col_q == '0));
          if (last_in) state_d = FLUSH;
        end
      end
      FLUSH: begin
        adv  = 1'b1;
        emit = 1'b1;
        if (last_out) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Input-side and output-side position counters
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    ocol_d = ocol_q;
    orow_d = orow_q;
    if (state_q == DONE) begin
      col_d  = '0;
      row_d  = '0;
      ocol_d = '0;
      orow_d = '0;
    end else begin
      if (adv) begin
        if (col_q == COL_LAST) begin
          col_d = '0;
          if (state_q != FLUSH) row_d = row_q + RW'(1);
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      if (emit) begin
        if (ocol_q == COL_LAST) begin
          ocol_d = '0;
          orow_d = orow_q + RW'(1);
        end else begin
          ocol_d = ocol_q + CW'(1);
        end
      end
    end
  end

  // Shift the window left by one column and load the new right column
  always_comb begin
    win_d = win_q;
    if (adv) begin
      for (int r = 0; r < 3; r++) begin
        win_d[(r*3 + 0)*DW +: DW] = win_q[(r*3 + 1)*DW +: DW];
        win_d[(r*3 + 1)*DW +: DW] = win_q[(r*3 + 2)*DW +: DW];
      end
      win_d[2*DW +: DW] = rd2;
      win_d[5*DW +: DW] = rd1;
      win_d[8*DW +: DW] = x;
    end
  end

  // Apply border handling for the centre position being emitted
  always_comb begin
    win_pad = '0;
    for (int k = 0; k < 9; k++) begin
      win_pad[k*DW +: DW] = pick(win_d, k, orow_q == '0, orow_q == ROW_LAST,
                                 ocol_q == '0, ocol_q == COL_LAST);
    end
  end

  // Control state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      ocol_q      <= '0;
      orow_q      <= '0;
      ready_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_eof_q   <= 1'b0;
      out_win_q   <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      ocol_q      <= ocol_d;
      orow_q      <= orow_d;
      ready_q     <= (state_d == IDLE) || (state_d == RUN);
      out_valid_q <= emit;
      out_eof_q   <= emit && last_out;
      if (emit) out_win_q <= win_pad;
    end
  end

  // Line buffers and raw window; contents are not reset
  always_ff @(posedge clk) begin
    if (adv) begin
      lb1_q[col_q] <= x;
      lb2_q[col_q] <= rd1;
      win_q        <= win_d;
    end
  end

endmodule

// File: tb/tb_line_buf_window.sv
// Bench for line_buf_window at IMG_W=4, IMG_H=3 with zero and replicate
// padding instances driven in parallel. A reference model of the window
// definition fills scoreboard queues at each frame start; a negedge monitor
// pops and compares every emitted window. Spec windows are also checked from
// a constant table.
module tb_line_buf_window;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_sof = 1'b0;
  logic [DW-1:0]   in_pixel = '0;
  logic            rdy_z, vld_z, eof_z, rdy_r, vld_r, eof_r;
  logic [9*DW-1:0] win_z, win_r;

  always #5 clk = ~clk;

  line_buf_window #(.DW(DW), .IMG_W(W), .IMG_H(H), .PAD_MODE(0)) u_z (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
    .in_pixel(in_pixel), .in_ready(rdy_z), .out_valid(vld_z),
    .out_win(win_z), .out_eof(eof_z));

  line_buf_window #(.DW(DW), .IMG_W(W), .IMG_H(H), .PAD_MODE(1)) u_r (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
    .in_pixel(in_pixel), .in_ready(rdy_r), .out_valid(vld_r),
    .out_win(win_r), .out_eof(eof_r));

  typedef struct {
    logic [9*DW-1:0] win;
    logic            eof;
  } exp_t;

  typedef struct {
    string           nm;
    bit              pad;
    int              m;
    logic [9*DW-1:0] win;
  } vec_t;

  int              n_vec = 0;
  int              n_err = 0;
  exp_t            q_z[$];
  exp_t            q_r[$];
  int              pix[N];
  int              cnt_z = 0, cnt_r = 0;
  logic [9*DW-1:0] cap_z[N], cap_r[N];
  logic [9*DW-1:0] last_z = '0, last_r = '0;
  vec_t            tbl[4];

  task automatic chk(input string nm, input logic [9*DW-1:0] act,
                     input logic [9*DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [9*DW-1:0] pk(input int a0, input int a1, input int a2,
                                         input int a3, input int a4, input int a5,
                                         input int a6, input int a7, input int a8);
    int t[9];
    logic [9*DW-1:0] v;
    t = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
    v = '0;
    for (int k = 0; k < 9; k++) v[k*DW +: DW] = DW'(t[k]);
    return v;
  endfunction

  // Window definition: tap k is p(r-1+k/3, c-1+k%3), padded at borders
  function automatic logic [9*DW-1:0] model(input int pad, input int r, input int c);
    logic [9*DW-1:0] v;
    int rr, cc;
    bit oob;
    v = '0;
    for (int k = 0; k < 9; k++) begin
      rr  = r - 1 + k / 3;
      cc  = c - 1 + k % 3;
      oob = (rr < 0) || (rr >= H) || (cc < 0) || (cc >= W);
      if (oob && pad == 0) begin
        v[k*DW +: DW] = '0;
      end else begin
        if (rr < 0) rr = 0;
        if (rr >= H) rr = H - 1;
        if (cc < 0) cc = 0;
        if (cc >= W) cc = W - 1;
        v[k*DW +: DW] = DW'(pix[rr*W + cc]);
      end
    end
    return v;
  endfunction

  task automatic push_frame();
    exp_t e;
    for (int m = 0; m < N; m++) begin
      e.eof = (m == N - 1);
      e.win = model(0, m / W, m % W);
      q_z.push_back(e);
      e.win = model(1, m / W, m % W);
      q_r.push_back(e);
    end
  endtask

  // Reset discards any expected windows and the held output value
  always @(posedge clk) begin
    if (!rst_n) begin
      q_z.delete();
      q_r.delete();
      last_z = '0;
      last_r = '0;
    end
  end

  // Output monitor: scoreboard compare, hold check and eof qualification
  always @(negedge clk) begin
    exp_t e;
    if (vld_z) begin
      if (q_z.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_win_z: got %h, expected no window", win_z);
      end else begin
        e = q_z.pop_front();
        chk("win_z", win_z, e.win);
        chk("eof_z", 72'(eof_z), 72'(e.eof));
        last_z = e.win;
      end
      if (cnt_z < N) cap_z[cnt_z] = win_z;
      cnt_z++;
    end else begin
      chk("hold_z", win_z, last_z);
      chk("eof_idle_z", 72'(eof_z), 72'(0));
    end
    if (vld_r) begin
      if (q_r.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_win_r: got %h, expected no window", win_r);
      end else begin
        e = q_r.pop_front();
        chk("win_r", win_r, e.win);
        chk("eof_r", 72'(eof_r), 72'(e.eof));
        last_r = e.win;
      end
      if (cnt_r < N) cap_r[cnt_r] = win_r;
      cnt_r++;
    end else begin
      chk("hold_r", win_r, last_r);
      chk("eof_idle_r", 72'(eof_r), 72'(0));
    end
  end

  task automatic set_ramp();
    for (int i = 0; i < N; i++) pix[i] = i + 1;
  endtask

  task automatic check_table(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_", tbl[i].nm}, tbl[i].pad ? cap_r[tbl[i].m] : cap_z[tbl[i].m],
          tbl[i].win);
    end
  endtask

  // Drive one frame; abort_at < N stops after that many pixels
  task automatic run_frame(input bit gaps, input int junk, input int midsof,
                           input int abort_at, input bit chk_lat);
    int lowc;
    for (int j = 0; j < junk; j++) begin
      in_valid = 1'b1; in_sof = 1'b0; in_pixel = 8'hAA;
      @(negedge clk);
      chk("junk_novld", 72'(vld_z), 72'(0));
    end
    in_valid = 1'b0;
    cnt_z = 0;
    cnt_r = 0;
    push_frame();
    for (int i = 0; i < N; i++) begin
      if (i == abort_at) break;
      chk("ready_run", 72'({rdy_z, rdy_r}), 72'(2'b11));
      in_valid = 1'b1;
      in_sof   = (i == 0) || (i == midsof);
      in_pixel = DW'(pix[i]);
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      if (chk_lat) chk("latency", 72'(vld_z), 72'(i >= W + 1));
      if (gaps && i < N - 1) begin
        repeat (2) begin
          @(negedge clk);
          chk("gap_novld", 72'({vld_z, vld_r}), 72'(0));
        end
      end
    end
    if (abort_at < N) return;
    lowc = 0;
    while (!rdy_z && lowc < 20) begin
      lowc++;
      @(negedge clk);
    end
    chk("ready_low_cycles", 72'(lowc), 72'(W + 2));
    chk("win_count_z", 72'(cnt_z), 72'(N));
    chk("win_count_r", 72'(cnt_r), 72'(N));
    chk("queue_drained", 72'(q_z.size() + q_r.size()), 72'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{"z_win00", 1'b0, 0,  pk(0, 0, 0, 0, 1, 2, 0, 5, 6)};
    tbl[1] = '{"z_win23", 1'b0, 11, pk(7, 8, 0, 11, 12, 0, 0, 0, 0)};
    tbl[2] = '{"r_win00", 1'b1, 0,  pk(1, 1, 2, 1, 1, 2, 5, 5, 6)};
    tbl[3] = '{"r_win12", 1'b1, 6,  pk(2, 3, 4, 6, 7, 8, 10, 11, 12)};

    // reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 72'({rdy_z, rdy_r}), 72'(0));
    chk("rst_valid", 72'({vld_z, vld_r}), 72'(0));
    chk("rst_win_z", win_z, '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 72'({rdy_z, rdy_r}), 72'(2'b11));

    // continuous ramp frame with first-window latency check
    set_ramp();
    run_frame(1'b0, 0, -1, N, 1'b1);
    check_table("cont");

    // random frame with idle junk and a mid-frame sof
    for (int i = 0; i < N; i++) pix[i] = $urandom_range(1, 255);
    run_frame(1'b0, 3, 6, N, 1'b0);

    // ramp frame with gaps in in_valid
    set_ramp();
    run_frame(1'b1, 0, -1, N, 1'b0);
    check_table("gap");

    // abandon a frame with a one-cycle reset, then a full frame
    run_frame(1'b0, 0, -1, 7, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("abort_novld", 72'({vld_z, vld_r}), 72'(0));
    end
    run_frame(1'b0, 0, -1, N, 1'b0);
    check_table("post_rst");

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
